// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and packing helpers used by the CP0 unit and its request arbiter.
package cp0_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned INT_W = 6;
  localparam int unsigned EXC_W = 5;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int unsigned SR_IE_BIT     = 0;
  localparam int unsigned SR_EXL_BIT    = 1;
  localparam int unsigned SR_IM_LSB     = 10;
  localparam int unsigned SR_IM_MSB     = 15;
  localparam int unsigned CAUSE_EXC_LSB = 2;
  localparam int unsigned CAUSE_EXC_MSB = 6;
  localparam int unsigned CAUSE_IP_LSB  = 10;
  localparam int unsigned CAUSE_IP_MSB  = 15;
  localparam int unsigned CAUSE_BD_BIT  = 31;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  localparam logic [XLEN-1:0] DEF_HANDLER_PC = 32'h0000_4180;
  localparam logic [XLEN-1:0] DEF_PRID       = 32'h5200_2020;
  localparam logic [XLEN-1:0] DEF_EPC_RESET  = 32'h0000_3000;
  localparam logic [XLEN-1:0] WORD_MASK      = 32'hFFFF_FFFC;

  // Exception record carried down the pipeline into the M stage
  typedef struct packed {
    logic             exc;
    logic [XLEN-1:0]  epc;
    logic [EXC_W-1:0] code;
    logic             bd;
  } exc_rec_t;

  function automatic logic [XLEN-1:0] sr_pack(input logic [INT_W-1:0] im,
                                              input logic exl,
                                              input logic ie);
    logic [XLEN-1:0] r;
    r = '0;
    r[SR_IM_MSB:SR_IM_LSB] = im;
    r[SR_EXL_BIT]          = exl;
    r[SR_IE_BIT]           = ie;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] cause_pack(input logic bd,
                                                 input logic [INT_W-1:0] ip,
                                                 input logic [EXC_W-1:0] code);
    logic [XLEN-1:0] r;
    r = '0;
    r[CAUSE_BD_BIT]                = bd;
    r[CAUSE_IP_MSB:CAUSE_IP_LSB]   = ip;
    r[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = code;
    return r;
  endfunction

  // Delay-slot faults restart at the branch, one word earlier (wraps mod 2^32)
  function automatic logic [XLEN-1:0] epc_target(input logic [XLEN-1:0] pc,
                                                 input logic bd);
    logic [XLEN-1:0] base;
    base = pc & WORD_MASK;
    return bd ? base - XLEN'(4) : base;
  endfunction

endpackage

// File: rtl/cp0_unit_req_arbiter.sv
// Combinational exception/interrupt arbiter: decides whether to trap this
// cycle and which ExcCode to record (interrupts beat synchronous exceptions).
module cp0_req_arbiter
  import cp0_defs::*;
(
  input  logic             sr_ie_i,
  input  logic             sr_exl_i,
  input  logic [INT_W-1:0] sr_im_i,
  input  logic [INT_W-1:0] hw_int_i,
  input  logic             exception_i,
  input  logic [EXC_W-1:0] exc_code_i,
  output logic             req_o,
  output logic [EXC_W-1:0] exc_code_o
);

  logic int_pend;
  logic exc_take;

  always_comb begin
    int_pend   = sr_ie_i & ~sr_exl_i & (|(hw_int_i & sr_im_i));
    exc_take   = exception_i & ~sr_exl_i;
    req_o      = int_pend | exc_take;
    exc_code_o = int_pend ? EXC_INT : exc_code_i;
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 at the M stage: SR/Cause/EPC/PRId, trap request with
// handler redirect, mtc0/mfc0 access and eret support.
module cp0_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
  parameter logic [31:0] PRID_VALUE = DEF_PRID,
  parameter logic [31:0] EPC_RESET  = DEF_EPC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exception_in,
  input  logic [31:0] EPC_in,
  input  logic [4:0]  ExcCode_in,
  input  logic        BD_in,
  input  logic [5:0]  HWInt,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret,
  output logic [31:0] cp0_rdata,
  output logic        req,
  output logic [31:0] redirect_pc,
  output logic [31:0] EPC_out,
  output logic        exl_out
);

  logic [INT_W-1:0] sr_im_q, sr_im_d;
  logic             sr_exl_q, sr_exl_d;
  logic             sr_ie_q, sr_ie_d;
  logic             cause_bd_q, cause_bd_d;
  logic [INT_W-1:0] cause_ip_q, cause_ip_d;
  logic [EXC_W-1:0] cause_exc_q, cause_exc_d;
  logic [XLEN-1:0]  epc_q, epc_d;

  exc_rec_t         rec;
  logic [EXC_W-1:0] sel_code;

  assign rec = '{exc: exception_in, epc: EPC_in, code: ExcCode_in, bd: BD_in};

  cp0_req_arbiter u_arb (
    .sr_ie_i     (sr_ie_q),
    .sr_exl_i    (sr_exl_q),
    .sr_im_i     (sr_im_q),
    .hw_int_i    (HWInt),
    .exception_i (rec.exc),
    .exc_code_i  (rec.code),
    .req_o       (req),
    .exc_code_o  (sel_code)
  );

  // Next-state: a trap overrides mtc0 and eret; eret's EXL clear beats mtc0 SR
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    cause_ip_d  = HWInt;
    if (req) begin
      sr_exl_d    = 1'b1;
      cause_bd_d  = rec.bd;
      cause_exc_d = sel_code;
      epc_d       = epc_target(rec.epc, rec.bd);
    end else begin
      if (cp0_we) begin
        case (cp0_addr)
          REG_SR: begin
            sr_im_d  = cp0_wdata[SR_IM_MSB:SR_IM_LSB];
            sr_exl_d = cp0_wdata[SR_EXL_BIT];
            sr_ie_d  = cp0_wdata[SR_IE_BIT];
          end
          REG_EPC: epc_d = cp0_wdata & WORD_MASK;
          default: ;
        endcase
      end
      if (eret) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= EPC_RESET;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  // mfc0 read port and redirect target, both from pre-edge state
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_SR:    cp0_rdata = sr_pack(sr_im_q, sr_exl_q, sr_ie_q);
      REG_CAUSE: cp0_rdata = cause_pack(cause_bd_q, cause_ip_q, cause_exc_q);
      REG_EPC:   cp0_rdata = epc_q;
      REG_PRID:  cp0_rdata = PRID_VALUE;
      default:   cp0_rdata = '0;
    endcase
    redirect_pc = req ? HANDLER_PC : epc_q;
  end

  assign EPC_out = epc_q;
  assign exl_out = sr_exl_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expectations are queued as stimulus is
// applied and drained against DUT outputs mid-cycle.
module tb_cp0_unit;
  import cp0_defs::*;

  localparam int SEL_RDATA = 0;
  localparam int SEL_REQ   = 1;
  localparam int SEL_REDIR = 2;
  localparam int SEL_EPC   = 3;
  localparam int SEL_EXL   = 4;

  logic        clk;
  logic        reset;
  logic        exception_in;
  logic [31:0] EPC_in;
  logic [4:0]  ExcCode_in;
  logic        BD_in;
  logic [5:0]  HWInt;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        eret;
  logic [31:0] cp0_rdata;
  logic        req;
  logic [31:0] redirect_pc;
  logic [31:0] EPC_out;
  logic        exl_out;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  cp0_unit dut (
    .clk         (clk),
    .reset       (reset),
    .exception_in(exception_in),
    .EPC_in      (EPC_in),
    .ExcCode_in  (ExcCode_in),
    .BD_in       (BD_in),
    .HWInt       (HWInt),
    .cp0_we      (cp0_we),
    .cp0_addr    (cp0_addr),
    .cp0_wdata   (cp0_wdata),
    .eret        (eret),
    .cp0_rdata   (cp0_rdata),
    .req         (req),
    .redirect_pc (redirect_pc),
    .EPC_out     (EPC_out),
    .exl_out     (exl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic settle();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_RDATA: obs = cp0_rdata;
        SEL_REQ:   obs = {31'd0, req};
        SEL_REDIR: obs = redirect_pc;
        SEL_EPC:   obs = EPC_out;
        default:   obs = {31'd0, exl_out};
      endcase
      check_val(e.tag, obs, e.val);
    end
  endtask

  task automatic drive(input logic exc, input logic [31:0] pc, input logic [4:0] code,
                       input logic bd, input logic [5:0] hw, input logic we,
                       input logic [4:0] addr, input logic [31:0] wd, input logic er);
    @(negedge clk);
    exception_in = exc;
    EPC_in       = pc;
    ExcCode_in   = code;
    BD_in        = bd;
    HWInt        = hw;
    cp0_we       = we;
    cp0_addr     = addr;
    cp0_wdata    = wd;
    eret         = er;
  endtask

  task automatic rd(input logic [4:0] addr, input string tag, input logic [31:0] val);
    @(negedge clk);
    exception_in = 1'b0;
    cp0_we       = 1'b0;
    eret         = 1'b0;
    cp0_addr     = addr;
    push(tag, SEL_RDATA, val);
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    exception_in = 1'b0; EPC_in = '0; ExcCode_in = '0; BD_in = 1'b0;
    HWInt = '0; cp0_we = 1'b0; cp0_addr = '0; cp0_wdata = '0; eret = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    @(negedge clk);
    reset = 1'b1;
    push("rst_req", SEL_REQ, 32'd0);
    push("rst_exl", SEL_EXL, 32'd0);
    push("rst_epc_out", SEL_EPC, 32'h3000);
    settle();
    rd(REG_SR, "rst_sr", 32'h0);
    rd(REG_CAUSE, "rst_cause", 32'h0);
    rd(REG_EPC, "rst_epc", 32'h3000);
    rd(REG_PRID, "rst_prid", 32'h5200_2020);
    rd(5'd3, "unimpl_rd", 32'h0);

    // plain exception
    drive(1'b1, 32'h3010, EXC_OV, 1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    push("exc_req", SEL_REQ, 32'd1);
    push("exc_redir", SEL_REDIR, 32'h4180);
    settle();
    drive(1'b1, 32'h3010, EXC_OV, 1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    push("exl_blocks_exc", SEL_REQ, 32'd0);
    push("exc_redir_epc", SEL_REDIR, 32'h3010);
    push("exc_exl", SEL_EXL, 32'd1);
    settle();
    rd(REG_EPC, "exc_epc", 32'h3010);
    rd(REG_CAUSE, "exc_cause", 32'h30);

    // eret
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b1);
    push("eret_req", SEL_REQ, 32'd0);
    settle();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    push("eret_exl", SEL_EXL, 32'd0);
    push("eret_epc_out", SEL_EPC, 32'h3010);
    settle();

    // delay-slot exception
    drive(1'b1, 32'h3024, EXC_ADEL, 1'b1, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    push("bd_req", SEL_REQ, 32'd1);
    settle();
    rd(REG_EPC, "bd_epc", 32'h3020);
    rd(REG_CAUSE, "bd_cause", 32'h8000_0010);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b1);

    // enable IM0/IE, then interrupt racing an exception
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'd0, 1'b1, REG_SR, 32'h0000_0401, 1'b0);
    push("mtc0_sr_req", SEL_REQ, 32'd0);
    settle();
    rd(REG_SR, "mtc0_sr", 32'h0000_0401);
    drive(1'b1, 32'h3040, EXC_RI, 1'b0, 6'b000001, 1'b0, 5'd0, 32'd0, 1'b0);
    push("int_req", SEL_REQ, 32'd1);
    push("int_redir", SEL_REDIR, 32'h4180);
    settle();
    rd(REG_CAUSE, "int_cause", 32'h400);
    rd(REG_EPC, "int_epc", 32'h3040);
    rd(REG_SR, "int_sr", 32'h403);

    // mtc0 SR (EXL=1, IE=0) with eret: eret clears EXL, IM/IE still written
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'b000001, 1'b1, REG_SR, 32'h0000_0402, 1'b1);
    push("sr_eret_req", SEL_REQ, 32'd0);
    settle();
    rd(REG_SR, "sr_eret_sr", 32'h400);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'b000001, 1'b0, 5'd0, 32'd0, 1'b0);
    push("ie0_req", SEL_REQ, 32'd0);
    settle();
    rd(REG_CAUSE, "ie0_cause_ip", 32'h400);

    // mtc0 EPC suppressed by a concurrent trap
    drive(1'b1, 32'h3050, EXC_ADES, 1'b0, 6'b000001, 1'b1, REG_EPC, 32'h3333, 1'b0);
    push("sup_req", SEL_REQ, 32'd1);
    settle();
    rd(REG_EPC, "sup_epc", 32'h3050);
    rd(REG_CAUSE, "sup_cause", 32'h414);
    rd(REG_SR, "sup_sr", 32'h402);

    // mtc0 EPC/Cause/PRId with no trap
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'b000001, 1'b0, 5'd0, 32'd0, 1'b1);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'b000001, 1'b1, REG_EPC, 32'h3337, 1'b0);
    push("wepc_req", SEL_REQ, 32'd0);
    settle();
    rd(REG_EPC, "wepc_epc", 32'h3334);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'b000001, 1'b1, REG_CAUSE, 32'hFFFF_FFFF, 1'b0);
    rd(REG_CAUSE, "wcause_ign", 32'h414);
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'b000001, 1'b1, REG_PRID, 32'h0, 1'b0);
    rd(REG_PRID, "wprid_ign", 32'h5200_2020);

    // delay-slot at PC 0 wraps
    drive(1'b1, 32'h0, EXC_OV, 1'b1, 6'b000001, 1'b0, 5'd0, 32'd0, 1'b0);
    push("wrap_req", SEL_REQ, 32'd1);
    settle();
    rd(REG_EPC, "wrap_epc", 32'hFFFF_FFFC);
    rd(REG_CAUSE, "wrap_cause", 32'h8000_0430);

    // interrupt enabled but EXL=1: no nesting
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'b000001, 1'b1, REG_SR, 32'h0000_0403, 1'b0);
    push("nest_wr_req", SEL_REQ, 32'd0);
    settle();
    drive(1'b0, 32'd0, 5'd0, 1'b0, 6'b000001, 1'b0, 5'd0, 32'd0, 1'b0);
    push("nest_req", SEL_REQ, 32'd0);
    push("nest_exl", SEL_EXL, 32'd1);
    settle();

    // reset mid-operation with HWInt active
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cp0_addr = REG_CAUSE;
    push("mrst_cause", SEL_RDATA, 32'h0);
    push("mrst_req", SEL_REQ, 32'd0);
    push("mrst_exl", SEL_EXL, 32'd0);
    push("mrst_epc_out", SEL_EPC, 32'h3000);
    settle();
    rd(REG_SR, "mrst_sr", 32'h0);
    rd(REG_EPC, "mrst_epc", 32'h3000);
    rd(REG_CAUSE, "mrst_ip_resume", 32'h400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
